// File: rtl/spi_paint_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_paint_decoder
// Purpose  : SPI slave front-end; decodes position/config packets for paint.
// Revision : 1.0 - initial release
// ============================================================================
module spi_paint_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  X_MAX       = 8'd159,
  parameter logic [7:0]  Y_MAX       = 8'd119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       brush,
  output logic [2:0] color,
  output logic       update_position,
  output logic       update_config,
  output logic       frame_error
);

  localparam logic [2:0] c_WAIT_IDLE = 3'd0;
  localparam logic [2:0] c_IDLE      = 3'd1;
  localparam logic [2:0] c_HEADER    = 3'd2;
  localparam logic [2:0] c_PAYLOAD   = 3'd3;
  localparam logic [2:0] c_DRAIN     = 3'd4;

  localparam logic [1:0] c_OP_POS = 2'b01;
  localparam logic [1:0] c_OP_CFG = 2'b10;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_cs_sync;
  logic                   r_sck_prev, r_cs_prev;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_byte_cnt;
  logic [2:0]             r_state, w_state_nxt;
  logic [1:0]             r_opcode;
  logic [7:0]             r_x_stg, r_y_stg;
  logic [3:0]             r_cfg_stg;
  logic [7:0]             r_x, r_y;
  logic                   r_brush;
  logic [2:0]             r_color;
  logic                   r_upd_pos, r_upd_cfg, r_frame_err;

  logic       w_sck, w_sdi, w_cs;
  logic       w_sck_rise, w_cs_fall, w_cs_rise;
  logic       w_bit_en, w_byte_done, w_cnt_clr;
  logic [7:0] w_byte;
  logic       w_hdr_legal, w_over, w_frame_ok;
  logic [1:0] w_pkt_len;
  logic       w_commit_pos, w_commit_cfg, w_frame_err;

  // cs synchronizer resets low so WAIT_IDLE only leaves on a real idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '0;
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_prev <= w_sck;
      r_cs_prev  <= w_cs;
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_cs_fall   = ~w_cs & r_cs_prev;
  assign w_cs_rise   = w_cs & ~r_cs_prev;
  assign w_bit_en    = w_sck_rise & ~w_cs;
  assign w_byte_done = w_bit_en & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift, w_sdi};
  assign w_cnt_clr   = (r_state == c_IDLE) & w_cs_fall;

  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (w_bit_en) begin
      r_shift   <= w_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_byte_done && (r_byte_cnt != 2'd3))
        r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign w_hdr_legal = (w_byte[7:6] == c_OP_POS) || (w_byte[7:6] == c_OP_CFG);
  assign w_pkt_len   = (r_opcode == c_OP_POS) ? 2'd3 : 2'd2;
  // r_byte_cnt is the index of the byte just completing (header = 0)
  assign w_over      = (r_byte_cnt >= w_pkt_len);
  assign w_frame_ok  = (r_bit_cnt == 3'd0) && (r_byte_cnt == w_pkt_len);

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_WAIT_IDLE: if (w_cs) w_state_nxt = c_IDLE;
      c_IDLE:      if (w_cs_fall) w_state_nxt = c_HEADER;
      c_HEADER: begin
        if (w_cs_rise)        w_state_nxt = c_IDLE;
        else if (w_byte_done) w_state_nxt = w_hdr_legal ? c_PAYLOAD : c_DRAIN;
      end
      c_PAYLOAD: begin
        if (w_cs_rise)                  w_state_nxt = c_IDLE;
        else if (w_byte_done && w_over) w_state_nxt = c_DRAIN;
      end
      c_DRAIN:     if (w_cs_rise) w_state_nxt = c_IDLE;
      default:     w_state_nxt = c_WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_commit_pos = 1'b0;
    w_commit_cfg = 1'b0;
    w_frame_err  = 1'b0;
    if (w_cs_rise) begin
      case (r_state)
        c_HEADER:  w_frame_err = 1'b1;
        c_PAYLOAD: begin
          w_commit_pos = w_frame_ok && (r_opcode == c_OP_POS);
          w_commit_cfg = w_frame_ok && (r_opcode == c_OP_CFG);
          w_frame_err  = !w_frame_ok;
        end
        c_DRAIN:   w_frame_err = 1'b1;
        default:   w_frame_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode    <= '0;
      r_x_stg     <= '0;
      r_y_stg     <= '0;
      r_cfg_stg   <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_brush     <= 1'b0;
      r_color     <= '0;
      r_upd_pos   <= 1'b0;
      r_upd_cfg   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_upd_pos   <= w_commit_pos;
      r_upd_cfg   <= w_commit_cfg;
      r_frame_err <= w_frame_err;
      if ((r_state == c_HEADER) && w_byte_done)
        r_opcode <= w_byte[7:6];
      if ((r_state == c_PAYLOAD) && w_byte_done) begin
        if ((r_opcode == c_OP_POS) && (r_byte_cnt == 2'd1)) r_x_stg   <= w_byte;
        if ((r_opcode == c_OP_POS) && (r_byte_cnt == 2'd2)) r_y_stg   <= w_byte;
        if ((r_opcode == c_OP_CFG) && (r_byte_cnt == 2'd1)) r_cfg_stg <= w_byte[3:0];
      end
      if (w_commit_pos) begin
        r_x <= (r_x_stg > X_MAX) ? X_MAX : r_x_stg;
        r_y <= (r_y_stg > Y_MAX) ? Y_MAX : r_y_stg;
      end
      if (w_commit_cfg) begin
        r_brush <= r_cfg_stg[3];
        r_color <= r_cfg_stg[2:0];
      end
    end
  end

  assign x               = r_x;
  assign y               = r_y;
  assign brush           = r_brush;
  assign color           = r_color;
  assign update_position = r_upd_pos;
  assign update_config   = r_upd_cfg;
  assign frame_error     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_paint_decoder.sv
`default_nettype none
// Directed bench for spi_paint_decoder: sck = clk/8, expected values hand-computed.
module tb_spi_paint_decoder;

  logic       clk = 1'b0;
  logic       reset, sck, sdi, cs;
  logic [7:0] x, y;
  logic       brush;
  logic [2:0] color;
  logic       update_position, update_config, frame_error;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_pos = 0, n_cfg = 0, n_err = 0, n_both = 0;
  time t_pos = 0, t_cfg = 0, t_cs_rise = 0;
  int  s_pos, s_cfg, s_err;

  spi_paint_decoder dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs),
    .x(x), .y(y), .brush(brush), .color(color),
    .update_position(update_position), .update_config(update_config),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update_position) begin n_pos++; t_pos = $time; end
    if (update_config)   begin n_cfg++; t_cfg = $time; end
    if (frame_error)     n_err++;
    if (update_position && update_config) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = d[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int nbits, input int gap_ns);
    cs = 1'b0;
    #60;
    send_bits(d, nbits);
    #60 cs = 1'b1;
    t_cs_rise = $time;
    #(gap_ns);
  endtask

  task automatic snap();
    s_pos = n_pos; s_cfg = n_cfg; s_err = n_err;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sck = 1'b0; sdi = 1'b0;
    #53;
    check("reset_outputs", {x, y, 1'b0, brush, 1'b0, color}, 32'h0);
    check("reset_strobes", {update_position, update_config, frame_error}, 32'h0);
    reset = 1'b0;
    #100;

    // POSITION 0x40,0x25,0x1A
    snap();
    send_frame(32'h0040251A, 24, 200);
    check("pos_xy", {x, y}, 32'h251A);
    check("pos_strobe", n_pos - s_pos, 1);
    check("pos_latency", ((t_pos - t_cs_rise) <= 50) ? 1 : 0, 1);
    check("pos_cfg_kept", {brush, color}, 32'h0);
    check("pos_no_other", (n_cfg - s_cfg) + (n_err - s_err), 0);

    // CONFIG 0x80,0x0D
    snap();
    send_frame(32'h0000800D, 16, 200);
    check("cfg_brush_color", {brush, color}, 32'hD);
    check("cfg_strobe", n_cfg - s_cfg, 1);
    check("cfg_xy_kept", {x, y}, 32'h251A);

    // sck activity with cs high must not produce anything
    snap();
    sdi = 1'b1;
    for (int i = 0; i < 8; i++) begin #40 sck = 1'b1; #40 sck = 1'b0; end
    #100;
    check("sck_cs_high_quiet", (n_pos - s_pos) + (n_cfg - s_cfg) + (n_err - s_err), 0);

    // POSITION 0x40,0xFF,0xC8 -> clamped
    snap();
    send_frame(32'h0040FFC8, 24, 200);
    check("clamp_xy", {x, y}, 32'h9F77);
    check("clamp_strobe", n_pos - s_pos, 1);

    // illegal header 0xC0 + 2 bytes
    snap();
    send_frame(32'h00C01122, 24, 200);
    check("illegal_err", n_err - s_err, 1);
    check("illegal_kept", {x, y, 4'h0, brush, color}, 32'h9F770D);
    check("illegal_no_upd", (n_pos - s_pos) + (n_cfg - s_cfg), 0);

    // CONFIG with only 5 data bits
    snap();
    send_frame({19'h0, 8'h80, 5'b01010}, 13, 200);
    check("short_err", n_err - s_err, 1);
    check("short_kept", {x, y, 4'h0, brush, color}, 32'h9F770D);
    check("short_no_upd", (n_pos - s_pos) + (n_cfg - s_cfg), 0);

    // POSITION with 4 bytes
    snap();
    send_frame(32'h40102030, 32, 200);
    check("long_err", n_err - s_err, 1);
    check("long_kept", {x, y, 4'h0, brush, color}, 32'h9F770D);
    check("long_no_upd", (n_pos - s_pos) + (n_cfg - s_cfg), 0);

    // reset in the middle of the x byte, cs stays low
    snap();
    cs = 1'b0;
    #60;
    send_bits(32'h00000402, 12);
    reset = 1'b1;
    #30;
    check("midreset_outputs", {x, y, 4'h0, brush, color}, 32'h0);
    reset = 1'b0;
    #30;
    send_bits(32'h0000051A, 12);
    #60 cs = 1'b1;
    #200;
    check("midreset_no_strobe", (n_pos - s_pos) + (n_cfg - s_cfg) + (n_err - s_err), 0);
    check("midreset_outputs_after", {x, y, 4'h0, brush, color}, 32'h0);
    snap();
    send_frame(32'h0000800A, 16, 200);
    check("postreset_cfg", {x, y, 4'h0, brush, color}, 32'h0A);
    check("postreset_strobe", n_cfg - s_cfg, 1);

    // back-to-back POSITION then CONFIG, cs high for 4 clk cycles
    snap();
    send_frame(32'h00400506, 24, 40);
    send_frame(32'h00008007, 16, 200);
    check("b2b_values", {x, y, 4'h0, brush, color}, 32'h050607);
    check("b2b_pos_count", n_pos - s_pos, 1);
    check("b2b_cfg_count", n_cfg - s_cfg, 1);
    check("b2b_no_err", n_err - s_err, 0);
    check("b2b_order", (t_pos < t_cfg) ? 1 : 0, 1);
    check("never_both_strobes", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
